// File: rtl/sonic_vc_st_timing_adapter.sv
// sonic_vc_st_timing_adapter: Avalon-ST ready-latency-N to ready-latency-0 adapter with show-ahead FIFO
// Ports: clk/reset (sync, active-high); in_* upstream Avalon-ST (in_valid honoured regardless
// of in_ready); out_* downstream Avalon-ST, ready latency 0; fill_level occupancy; overflow and
// framing_err sticky flags; pkt_count/drop_count statistics.
// Build option: define SONIC_VC_ST_ADAPTER_STATS_EN to enable the counters (tied to 0 otherwise).
module sonic_vc_st_timing_adapter #(
  parameter int DATA_W    = 128,
  parameter int CHANNEL_W = 1,
  parameter int EMPTY_W   = 2,
  parameter int DEPTH     = 8,
  parameter int READY_LAT = 3,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       in_ready,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [CHANNEL_W-1:0]       in_channel,
  input  logic                       in_startofpacket,
  input  logic                       in_endofpacket,
  input  logic [EMPTY_W-1:0]         in_empty,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [CHANNEL_W-1:0]       out_channel,
  output logic                       out_startofpacket,
  output logic                       out_endofpacket,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       overflow,
  output logic                       framing_err,
  output logic [CNT_W-1:0]           pkt_count,
  output logic [CNT_W-1:0]           drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);
  localparam int PW = DATA_W + CHANNEL_W + EMPTY_W + 2;
  typedef enum logic {IDLE, IN_PKT} state_t;
  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          overflow_q, overflow_d, framing_err_q, framing_err_d;
  state_t        state_q, state_d;
  logic          push, pop;
  always_comb begin
    pop           = (fill_q != '0) & out_ready;
    // a full FIFO still accepts a beat when the head leaves in the same cycle
    push          = in_valid & ((fill_q != FW'(DEPTH)) | pop);
    wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d        = fill_q + FW'(push) - FW'(pop);
    overflow_d    = overflow_q | (in_valid & ~push);
    // framing is tracked on every beat seen, including dropped ones
    framing_err_d = framing_err_q | (in_valid & ((state_q == IDLE) ? ~in_startofpacket : in_startofpacket));
    state_d       = ~in_valid ? state_q : in_endofpacket ? IDLE : in_startofpacket ? IN_PKT : state_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      overflow_q    <= 1'b0;
      framing_err_q <= 1'b0;
      state_q       <= IDLE;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      overflow_q    <= overflow_d;
      framing_err_q <= framing_err_d;
      state_q       <= state_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= {in_data, in_channel, in_startofpacket, in_endofpacket, in_empty};
  assign {out_data, out_channel, out_startofpacket, out_endofpacket, out_empty} = mem[rd_ptr_q];
  assign out_valid   = fill_q != '0;
  assign fill_level  = fill_q;
  assign in_ready    = (FW'(DEPTH) - fill_q) > FW'(READY_LAT);
  assign overflow    = overflow_q;
  assign framing_err = framing_err_q;
`ifdef SONIC_VC_ST_ADAPTER_STATS_EN
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d, drop_count_q, drop_count_d;
  always_comb begin
    pkt_count_d  = pkt_count_q + CNT_W'(push & in_endofpacket);
    drop_count_d = drop_count_q + CNT_W'(in_valid & ~push);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end
  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
`else
  assign pkt_count  = '0;
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_sonic_vc_st_timing_adapter.sv
// tb_sonic_vc_st_timing_adapter: directed bench with a queue-based reference model
module tb_sonic_vc_st_timing_adapter;
  localparam int DATA_W = 128, CHANNEL_W = 1, EMPTY_W = 2, DEPTH = 8, READY_LAT = 3, CNT_W = 32;
  localparam int FW = $clog2(DEPTH+1);
  localparam int PW = DATA_W + CHANNEL_W + EMPTY_W + 2;
`ifdef SONIC_VC_ST_ADAPTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic in_ready, in_valid, in_startofpacket, in_endofpacket, out_ready, out_valid;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CHANNEL_W-1:0] in_channel, out_channel;
  logic [EMPTY_W-1:0] in_empty, out_empty;
  logic out_startofpacket, out_endofpacket, overflow, framing_err;
  logic [FW-1:0] fill_level;
  logic [CNT_W-1:0] pkt_count, drop_count;
  sonic_vc_st_timing_adapter #(.DATA_W(DATA_W), .CHANNEL_W(CHANNEL_W), .EMPTY_W(EMPTY_W),
    .DEPTH(DEPTH), .READY_LAT(READY_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_channel(in_channel), .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .in_empty(in_empty), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_channel(out_channel), .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_empty(out_empty), .fill_level(fill_level), .overflow(overflow), .framing_err(framing_err),
    .pkt_count(pkt_count), .drop_count(drop_count));
  always #5 clk = ~clk;
  int tests = 0, errs = 0;
  bit chk_en = 1'b0;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // reference model: a plain queue of payloads plus sticky flags and counts
  logic [PW-1:0] mq[$];
  bit m_inpkt, m_ovf, m_ferr;
  int unsigned m_pkt, m_drop;
  always @(posedge clk) begin
    bit p, w;
    if (reset) begin
      mq.delete();
      m_inpkt = 0; m_ovf = 0; m_ferr = 0; m_pkt = 0; m_drop = 0;
    end else begin
      p = mq.size() != 0 && out_ready;
      w = in_valid && (mq.size() < DEPTH || p);
      if (p) void'(mq.pop_front());
      if (w) begin
        mq.push_back({in_data, in_channel, in_startofpacket, in_endofpacket, in_empty});
        if (in_endofpacket) m_pkt++;
      end else if (in_valid) begin
        m_ovf = 1; m_drop++;
      end
      if (in_valid) begin
        if (in_startofpacket) begin
          if (m_inpkt) m_ferr = 1;
          m_inpkt = !in_endofpacket;
        end else if (!m_inpkt) m_ferr = 1;
        else if (in_endofpacket) m_inpkt = 0;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("out_valid", 256'(out_valid), 256'(mq.size() != 0));
    if (mq.size() != 0)
      chk("payload", 256'({out_data, out_channel, out_startofpacket, out_endofpacket, out_empty}), 256'(mq[0]));
    chk("fill_level", 256'(fill_level), 256'(mq.size()));
    chk("in_ready", 256'(in_ready), 256'((DEPTH - mq.size()) > READY_LAT));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    chk("framing_err", 256'(framing_err), 256'(m_ferr));
    chk("pkt_count", 256'(pkt_count), STATS ? 256'(m_pkt) : 256'(0));
    chk("drop_count", 256'(drop_count), STATS ? 256'(m_drop) : 256'(0));
  end
  task automatic beat(input bit s, input bit e, input logic [DATA_W-1:0] d, input logic [CHANNEL_W-1:0] ch, input logic [EMPTY_W-1:0] em);
    @(negedge clk);
    in_valid = 1'b1; in_startofpacket = s; in_endofpacket = e; in_data = d; in_channel = ch; in_empty = em;
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_channel = '0;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_fill", 256'(fill_level), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    reset = 1'b0;
    // 1: single-beat packet, 1-cycle latency
    out_ready = 1'b1;
    beat(1, 1, {4{32'hA5A5A5A5}}, 1'b1, 2'd2);
    idle();
    chk("t1_out_valid", 256'(out_valid), 256'(1));
    chk("t1_out_data", 256'(out_data), 256'({4{32'hA5A5A5A5}}));
    chk("t1_out_ch_sop_eop_empty", 256'({out_channel, out_startofpacket, out_endofpacket, out_empty}), 256'(5'b1_1_1_10));
    idle();
    chk("t1_fill_back_0", 256'(fill_level), 256'(0));
    // 2: hold 5 beats, in_ready drops at fill 5, release back-to-back in order
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat(i == 0, i == 4, {4{32'h20000000 + i}}, i[0], i[1:0]);
      if (i == 4) chk("t2_in_ready_at_4", 256'(in_ready), 256'(1));
    end
    idle();
    chk("t2_fill_5", 256'(fill_level), 256'(5));
    chk("t2_in_ready_low", 256'(in_ready), 256'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_order_valid", 256'(out_valid), 256'(1));
      chk("t2_order_data", 256'(out_data), 256'({4{32'h20000000 + i}}));
      idle();
    end
    chk("t2_drained", 256'(fill_level), 256'(0));
    // 3: nine beats into 8 slots with no drain
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) beat(i == 0, i == 8, {4{32'h30000000 + i}}, 1'b0, 2'd0);
    idle();
    chk("t3_fill_8", 256'(fill_level), 256'(8));
    chk("t3_overflow", 256'(overflow), 256'(1));
    chk("t3_drop_count", 256'(drop_count), STATS ? 256'(1) : 256'(0));
    chk("t3_head", 256'(out_data), 256'({4{32'h30000000}}));
    out_ready = 1'b1;
    repeat (9) idle();
    do_reset();
    chk("t3_overflow_cleared", 256'(overflow), 256'(0));
    // 4: full FIFO, push and pop in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) beat(i == 0, 0, {4{32'h40000000 + i}}, 1'b0, 2'd1);
    beat(0, 1, {4{32'h40000008}}, 1'b1, 2'd3);
    out_ready = 1'b1;
    idle();
    out_ready = 1'b0;
    chk("t4_fill_8", 256'(fill_level), 256'(8));
    chk("t4_no_overflow", 256'(overflow), 256'(0));
    chk("t4_head", 256'(out_data), 256'({4{32'h40000001}}));
    out_ready = 1'b1;
    repeat (9) idle();
    chk("t4_drained", 256'(fill_level), 256'(0));
    // 5: sop, mid, sop (violation), eop
    beat(1, 0, {4{32'h50000000}}, 1'b0, 2'd0);
    beat(0, 0, {4{32'h50000001}}, 1'b1, 2'd0);
    beat(1, 0, {4{32'h50000002}}, 1'b0, 2'd0);
    chk("t5_no_err_yet", 256'(framing_err), 256'(0));
    beat(0, 1, {4{32'h50000003}}, 1'b1, 2'd3);
    chk("t5_framing_err", 256'(framing_err), 256'(1));
    chk("t5_third_beat_sop", 256'({out_data, out_startofpacket}), 256'({{4{32'h50000002}}, 1'b1}));
    repeat (5) idle();
    // 6: reset with 6 beats stored mid-packet
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) beat(i == 0, 0, {4{32'h60000000 + i}}, 1'b0, 2'd0);
    idle();
    chk("t6_fill_6", 256'(fill_level), 256'(6));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_fill_0", 256'(fill_level), 256'(0));
    chk("t6_out_valid_0", 256'(out_valid), 256'(0));
    chk("t6_in_ready_1", 256'(in_ready), 256'(1));
    chk("t6_flags_0", 256'({overflow, framing_err}), 256'(0));
    chk("t6_counters_0", 256'({pkt_count, drop_count}), 256'(0));
    reset = 1'b0;
    out_ready = 1'b1;
    beat(1, 1, {4{32'h70000000}}, 1'b1, 2'd1);
    repeat (3) idle();
    chk("t6_post_reset_err", 256'(framing_err), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
